// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett parameter generator and reducer.
// Holds default widths, the generator state encoding and a count-width helper.
package barrett_pkg;

   localparam int MOD_W_DEF = 32;
   localparam int WIDTH_DEF = 64;

   typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} mu_state_e;

   // Wide enough to hold 2k for the largest k.
   function automatic int cnt_w(input int mw);
      return $clog2(2 * mw + 1);
   endfunction

   localparam int CW = cnt_w(MOD_W_DEF);

endpackage

// File: rtl/barrett_mu_gen_msb_index.sv
// Combinational priority encoder returning the index of the highest set bit.
// zero_o flags an all-zero input; idx_o is 0 in that case.
module msb_index #(
   parameter  int W  = 32,
   localparam int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  in_i,
   output logic [IW-1:0] idx_o,
   output logic          zero_o
);

   always_comb begin
      idx_o  = '0;
      zero_o = ~|in_i;
      for (int b = 0; b < W; b++) begin
         if (in_i[b]) idx_o = IW'(b);
      end
   end

endmodule

// File: rtl/barrett_mu_gen.sv
// Computes bit length k and mu = floor(2^(2k)/m) for a runtime modulus,
// one restoring-division step per cycle, results held until the next run.
//
// state | meaning
// IDLE  | waiting for start_i; modulus captured on accept
// NORM  | find k from the MSB of m; clear r/q, load counter with 2k
// DIV   | one quotient bit per cycle, 2k+1 cycles; outputs load on exit
// DONE  | valid_o (and err_o for m == 0) pulse for one cycle
module barrett_mu_gen
   import barrett_pkg::*;
#(
   parameter  int MOD_W = MOD_W_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int KW    = $clog2(MOD_W + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [MOD_W-1:0] m_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic             err_o,
   output logic [KW-1:0]    k_o,
   output logic [WIDTH-1:0] m_o,
   output logic [WIDTH-1:0] mu_o
);

   localparam int CWL = cnt_w(MOD_W);
   localparam int IW  = (MOD_W > 1) ? $clog2(MOD_W) : 1;

   mu_state_e        r_state;
   mu_state_e        w_state_nxt;

   logic [MOD_W-1:0] r_m;
   logic [KW-1:0]    r_k;
   logic             r_err;
   logic [MOD_W:0]   r_r;
   logic [MOD_W:0]   r_q;
   logic [CWL-1:0]   r_i;
   logic [KW-1:0]    r_k_o;
   logic [MOD_W-1:0] r_m_o;
   logic [MOD_W+1:0] r_mu_o;

   logic [IW-1:0]    w_idx;
   logic             w_zero;
   logic [KW-1:0]    w_k;
   logic [CWL-1:0]   w_two_k_norm;
   logic [CWL-1:0]   w_two_k;
   logic             w_b;
   logic [MOD_W+1:0] w_t;
   logic             w_ge;
   logic [MOD_W:0]   w_diff;
   logic [MOD_W+1:0] w_q_nxt;

   msb_index #(.W(MOD_W)) u_msb (
      .in_i   (r_m),
      .idx_o  (w_idx),
      .zero_o (w_zero)
   );

   assign w_k          = w_zero ? '0 : KW'(w_idx) + KW'(1);
   assign w_two_k_norm = CWL'({w_k, 1'b0});
   assign w_two_k      = CWL'({r_k, 1'b0});

   // Dividend 2^(2k) has a single 1 at the first bit fed in.
   assign w_b     = (r_i == w_two_k);
   assign w_t     = {r_r, w_b};
   assign w_ge    = (w_t >= {2'b00, r_m});
   assign w_diff  = w_t[MOD_W:0] - {1'b0, r_m};
   assign w_q_nxt = {r_q, w_ge};

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start_i) w_state_nxt = NORM;
         NORM: w_state_nxt = DIV;
         DIV:  if (r_i == '0) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_m    <= '0;
         r_k    <= '0;
         r_err  <= 1'b0;
         r_r    <= '0;
         r_q    <= '0;
         r_i    <= '0;
         r_k_o  <= '0;
         r_m_o  <= '0;
         r_mu_o <= '0;
      end else begin
         case (r_state)
            IDLE: if (start_i) r_m <= m_i;
            NORM: begin
               // m == 0 runs a single dummy step (k = 0) and reports err.
               r_k   <= w_k;
               r_err <= w_zero;
               r_r   <= '0;
               r_q   <= '0;
               r_i   <= w_two_k_norm;
            end
            DIV: begin
               r_r <= w_ge ? w_diff : w_t[MOD_W:0];
               r_q <= w_q_nxt[MOD_W:0];
               if (r_i == '0) begin
                  r_k_o  <= r_k;
                  r_m_o  <= r_m;
                  r_mu_o <= r_err ? '0 : w_q_nxt;
               end else begin
                  r_i <= r_i - CWL'(1);
               end
            end
            DONE: ;
         endcase
      end
   end

   assign busy_o  = (r_state != IDLE);
   assign valid_o = (r_state == DONE);
   assign err_o   = valid_o & r_err;
   assign k_o     = r_k_o;
   assign m_o     = WIDTH'(r_m_o);
   assign mu_o    = WIDTH'(r_mu_o);

endmodule
